// File: rtl/icache_line_fetch.sv
// ============================================================================
// icache_line_fetch
// ----------------------------------------------------------------------------
// Direct-mapped, read-only instruction-cache line stage. For every accepted
// fetch address it presents the whole cache line plus the byte offset of the
// fetch within that line, one cycle later. The word selector downstream does
// the final instruction extraction.
//
// A hit is served straight from the flop-based data array. On a miss, or on
// any request that coincides with a flush, the stage raises stall, issues a
// line-aligned memory request, waits for mem_ready, writes the returned line
// into the array and forwards it in the following cycle.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high reset
//   req         fetch request valid
//   pc          fetch byte address
//   flush       invalidate every line in the cycle it is sampled
//   stall       fetch must hold pc/req (combinational)
//   line_valid  line/offset valid this cycle (registered)
//   line        selected cache line (registered)
//   offset      byte offset of the fetch within line (registered)
//   mem_req     memory line request (registered)
//   mem_addr    line-aligned memory address (registered)
//   mem_ready   mem_line valid, consumed in the same cycle
//   mem_line    line returned by memory
//   hit_count   saturating hit counter
//   miss_count  saturating miss counter
// ============================================================================

`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif
`ifndef LINE_NB_BYTES
`define LINE_NB_BYTES 16
`endif

module icache_line_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int NB_LINES   = 4,
   localparam int OFF_W     = $clog2(`LINE_NB_BYTES),
   localparam int IDX_W     = $clog2(NB_LINES),
   localparam int TAG_W     = ADDR_WIDTH - IDX_W - OFF_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req,
   input  logic [ADDR_WIDTH-1:0]   pc,
   input  logic                    flush,
   output logic                    stall,
   output logic                    line_valid,
   output logic [`LINE_WIDTH-1:0]  line,
   output logic [OFF_W-1:0]        offset,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_ready,
   input  logic [`LINE_WIDTH-1:0]  mem_line,
   output logic [15:0]             hit_count,
   output logic [15:0]             miss_count
);

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   state_e                  state_q, state_d;

   logic [NB_LINES-1:0]     valid_q, valid_d;
   logic [TAG_W-1:0]        tag_q  [NB_LINES];
   logic [TAG_W-1:0]        tag_d  [NB_LINES];
   logic [`LINE_WIDTH-1:0]  data_q [NB_LINES];
   logic [`LINE_WIDTH-1:0]  data_d [NB_LINES];

   // Miss context latched when the miss is accepted.
   logic [TAG_W-1:0]        lat_tag_q, lat_tag_d;
   logic [IDX_W-1:0]        lat_idx_q, lat_idx_d;
   logic [OFF_W-1:0]        lat_off_q, lat_off_d;

   logic                    line_valid_q, line_valid_d;
   logic [`LINE_WIDTH-1:0]  line_q, line_d;
   logic [OFF_W-1:0]        offset_q, offset_d;
   logic                    mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [15:0]             hit_count_q, hit_count_d;
   logic [15:0]             miss_count_q, miss_count_d;

   // ---------------------------------------------------------------------
   // Address decode and lookup
   // ---------------------------------------------------------------------
   logic [OFF_W-1:0]        pc_off_s;
   logic [IDX_W-1:0]        pc_idx_s;
   logic [TAG_W-1:0]        pc_tag_s;
   logic                    hit_s;
   logic                    accept_hit_s;
   logic                    accept_miss_s;
   logic                    fill_s;
   logic                    stall_s;

   assign pc_off_s = pc[OFF_W-1:0];
   assign pc_idx_s = pc[OFF_W+IDX_W-1:OFF_W];
   assign pc_tag_s = pc[ADDR_WIDTH-1:OFF_W+IDX_W];

   assign hit_s = valid_q[pc_idx_s] & (tag_q[pc_idx_s] == pc_tag_s);

   // A flush that arrives with a request forces the request down the miss
   // path, even if the line was resident before the flush.
   assign accept_hit_s  = (state_q == ST_IDLE) & req & hit_s & ~flush;
   assign accept_miss_s = (state_q == ST_IDLE) & req & (~hit_s | flush);
   assign fill_s        = (state_q == ST_MEM_WAIT) & mem_ready;

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_miss_s) begin
               state_d = ST_MEM_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_MEM_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM output logic: stall, array updates and next values of all outputs
   always_comb begin
      stall_s      = 1'b0;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      lat_tag_d    = lat_tag_q;
      lat_idx_d    = lat_idx_q;
      lat_off_d    = lat_off_q;
      line_valid_d = 1'b0;
      line_d       = line_q;
      offset_d     = offset_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;

      // Flush clears first so that a fill in the same cycle still lands.
      if (flush) begin
         valid_d = {NB_LINES{1'b0}};
      end else begin
         valid_d = valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_hit_s) begin
               line_valid_d = 1'b1;
               line_d       = data_q[pc_idx_s];
               offset_d     = pc_off_s;
               if (hit_count_q != CNT_MAX) begin
                  hit_count_d = hit_count_q + 16'd1;
               end else begin
                  hit_count_d = hit_count_q;
               end
            end else if (accept_miss_s) begin
               stall_s    = 1'b1;
               lat_tag_d  = pc_tag_s;
               lat_idx_d  = pc_idx_s;
               lat_off_d  = pc_off_s;
               mem_req_d  = 1'b1;
               mem_addr_d = {pc_tag_s, pc_idx_s, {OFF_W{1'b0}}};
               if (miss_count_q != CNT_MAX) begin
                  miss_count_d = miss_count_q + 16'd1;
               end else begin
                  miss_count_d = miss_count_q;
               end
            end else begin
               stall_s = 1'b0;
            end
         end
         ST_MEM_WAIT: begin
            stall_s = 1'b1;
            if (fill_s) begin
               valid_d[lat_idx_q] = 1'b1;
               tag_d[lat_idx_q]   = lat_tag_q;
               data_d[lat_idx_q]  = mem_line;
               mem_req_d          = 1'b0;
               line_valid_d       = 1'b1;
               line_d             = mem_line;
               offset_d           = lat_off_q;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         default: begin
            stall_s = 1'b0;
         end
      endcase
   end

   // Datapath, arrays and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q      <= {NB_LINES{1'b0}};
         for (int i = 0; i < NB_LINES; i++) begin
            tag_q[i]  <= {TAG_W{1'b0}};
            data_q[i] <= {`LINE_WIDTH{1'b0}};
         end
         lat_tag_q    <= {TAG_W{1'b0}};
         lat_idx_q    <= {IDX_W{1'b0}};
         lat_off_q    <= {OFF_W{1'b0}};
         line_valid_q <= 1'b0;
         line_q       <= {`LINE_WIDTH{1'b0}};
         offset_q     <= {OFF_W{1'b0}};
         mem_req_q    <= 1'b0;
         mem_addr_q   <= {ADDR_WIDTH{1'b0}};
         hit_count_q  <= 16'd0;
         miss_count_q <= 16'd0;
      end else begin
         valid_q      <= valid_d;
         for (int i = 0; i < NB_LINES; i++) begin
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
         lat_tag_q    <= lat_tag_d;
         lat_idx_q    <= lat_idx_d;
         lat_off_q    <= lat_off_d;
         line_valid_q <= line_valid_d;
         line_q       <= line_d;
         offset_q     <= offset_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign stall      = stall_s;
   assign line_valid = line_valid_q;
   assign line       = line_q;
   assign offset     = offset_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_line_fetch.sv
`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif
`ifndef LINE_NB_BYTES
`define LINE_NB_BYTES 16
`endif

module tb_icache_line_fetch;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [31:0]   pc;
   logic          flush;
   logic          stall;
   logic          line_valid;
   logic [127:0]  line;
   logic [3:0]    offset;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_ready;
   logic [127:0]  mem_line;
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;

   typedef struct packed {
      logic [127:0] line;
      logic [3:0]   off;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_bad    = 0;
   int   exp_hits = 0;
   int   exp_miss = 0;

   always #5 clk = ~clk;

   icache_line_fetch #(.ADDR_WIDTH(32), .NB_LINES(4)) dut (
      .clk(clk), .reset(reset), .req(req), .pc(pc), .flush(flush),
      .stall(stall), .line_valid(line_valid), .line(line), .offset(offset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_line(mem_line), .hit_count(hit_count), .miss_count(miss_count)
   );

   // Memory contents: a fixed, address-dependent pattern per line.
   function automatic logic [127:0] mem_model(input logic [31:0] a);
      return {a ^ 32'h1357_9BDF, a ^ 32'h2468_ACE0, a + 32'h0000_0011, ~a};
   endfunction

   function automatic logic [15:0] sat(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   // One fetch: hit or miss, with the memory answering dly cycles after mem_req rises.
   task automatic fetch(input logic [31:0] a, input bit exp_hit, input int dly, input bit with_flush);
      logic [31:0] al;
      exp_t        e;
      al = {a[31:4], 4'h0};
      @(posedge clk); #1;
      req = 1'b1; pc = a; flush = with_flush;
      sb_q.push_back({mem_model(al), a[3:0]});
      @(negedge clk);
      n_checks++;
      if (stall !== !exp_hit) begin
         n_bad++; $display("FAIL accept_stall pc=%h got=%b exp=%b", a, stall, !exp_hit);
      end
      @(posedge clk); #1;
      req = 1'b0; flush = 1'b0; pc = $urandom;
      if (exp_hit) begin
         exp_hits++;
      end else begin
         exp_miss++;
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b1 || mem_addr !== al || stall !== 1'b1 || line_valid !== 1'b0) begin
            n_bad++; $display("FAIL miss_req pc=%h got req=%b addr=%h stall=%b lv=%b exp req=1 addr=%h stall=1 lv=0",
                              a, mem_req, mem_addr, stall, line_valid, al);
         end
         repeat (dly) @(posedge clk);
         #1;
         mem_ready = 1'b1; mem_line = mem_model(al);
         @(negedge clk);
         n_checks++;
         if (stall !== 1'b1 || mem_req !== 1'b1) begin
            n_bad++; $display("FAIL miss_hold got stall=%b req=%b exp 1 1", stall, mem_req);
         end
         @(posedge clk); #1;
         mem_ready = 1'b0; mem_line = {4{$urandom}};
      end
      @(negedge clk);
      n_checks++;
      if (line_valid !== 1'b1 || sb_q.size() == 0) begin
         n_bad++; $display("FAIL line_valid pc=%h got=%b exp=1", a, line_valid);
         sb_q.delete();
      end else begin
         e = sb_q.pop_front();
         if (line !== e.line || offset !== e.off) begin
            n_bad++; $display("FAIL line_data pc=%h got=%h/%h exp=%h/%h", a, line, offset, e.line, e.off);
         end
      end
      n_checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0) begin
         n_bad++; $display("FAIL after_fetch got req=%b stall=%b exp 0 0", mem_req, stall);
      end
      n_checks++;
      if (hit_count !== sat(exp_hits) || miss_count !== sat(exp_miss)) begin
         n_bad++; $display("FAIL counters got h=%0d m=%0d exp h=%0d m=%0d", hit_count, miss_count, sat(exp_hits), sat(exp_miss));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 1'b0; pc = 32'h0; flush = 1'b0; mem_ready = 1'b0; mem_line = 128'h0;
      #3;
      n_checks++;
      if (line_valid !== 1'b0 || line !== 128'h0 || offset !== 4'h0 || mem_req !== 1'b0 ||
          mem_addr !== 32'h0 || hit_count !== 16'h0 || miss_count !== 16'h0 || stall !== 1'b0) begin
         n_bad++; $display("FAIL reset_vals got lv=%b off=%h req=%b addr=%h h=%0d m=%0d stall=%b exp all 0",
                           line_valid, offset, mem_req, mem_addr, hit_count, miss_count, stall);
      end
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (line_valid !== 1'b0) begin
         n_bad++; $display("FAIL idle_lv got=%b exp=0", line_valid);
      end
   endtask

   task automatic test_cold_and_hit();
      fetch(32'h0000_0100, 1'b0, 3, 1'b0);
      fetch(32'h0000_010C, 1'b1, 0, 1'b0);
   endtask

   task automatic test_flush();
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      fetch(32'h0000_0100, 1'b0, 1, 1'b0);
      fetch(32'h0000_0104, 1'b0, 2, 1'b1);
      fetch(32'h0000_0108, 1'b1, 0, 1'b0);
   endtask

   task automatic test_conflict();
      fetch(32'h0000_0140, 1'b0, 2, 1'b0);
      fetch(32'h0000_0148, 1'b1, 0, 1'b0);
      fetch(32'h0000_0100, 1'b0, 1, 1'b0);
      fetch(32'h0000_0230, 1'b0, 4, 1'b0);
      fetch(32'h0000_0104, 1'b1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         req = (i < 4); pc = (i < 4) ? (32'h0000_0100 + 32'(i * 4)) : 32'h0;
         if (i < 4) begin
            sb_q.push_back({mem_model(32'h0000_0100), pc[3:0]});
            exp_hits++;
         end
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (line_valid !== 1'b1 || sb_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, line_valid);
            end else begin
               e = sb_q.pop_front();
               if (line !== e.line || offset !== e.off) begin
                  n_bad++; $display("FAIL b2b_data beat=%0d got=%h/%h exp=%h/%h", i, line, offset, e.line, e.off);
               end
            end
         end
      end
      n_checks++;
      if (hit_count !== sat(exp_hits)) begin
         n_bad++; $display("FAIL b2b_hits got=%0d exp=%0d", hit_count, sat(exp_hits));
      end
   endtask

   task automatic test_stray_ready();
      @(posedge clk); #1; mem_ready = 1'b1; mem_line = {4{32'hDEAD_BEEF}};
      @(posedge clk); #1; mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (line_valid !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++; $display("FAIL stray_ready got lv=%b req=%b exp 0 0", line_valid, mem_req);
      end
      fetch(32'h0000_010C, 1'b1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_miss();
      @(posedge clk); #1; req = 1'b1; pc = 32'h0000_0240; flush = 1'b1;
      @(posedge clk); #1; req = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1) begin
         n_bad++; $display("FAIL mid_miss_req got=%b exp=1", mem_req);
      end
      #1; reset = 1'b1; mem_ready = 1'b1; mem_line = mem_model(32'h0000_0240);
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || stall !== 1'b0 || miss_count !== 16'h0) begin
         n_bad++; $display("FAIL reset_mid got req=%b stall=%b m=%0d exp 0 0 0", mem_req, stall, miss_count);
      end
      @(posedge clk); #1; reset = 1'b0; mem_ready = 1'b0;
      exp_hits = 0; exp_miss = 0;
      fetch(32'h0000_0100, 1'b0, 2, 1'b0);
      fetch(32'h0000_0240, 1'b0, 1, 1'b0);
   endtask

   task automatic test_saturation();
      @(posedge clk); #1; req = 1'b1; pc = 32'h0000_0244;
      repeat (65540) @(posedge clk);
      #1; req = 1'b0;
      exp_hits += 65540;
      sb_q.delete();
      @(negedge clk);
      n_checks++;
      if (hit_count !== 16'hFFFF || hit_count !== sat(exp_hits)) begin
         n_bad++; $display("FAIL hit_sat got=%h exp=%h", hit_count, 16'hFFFF);
      end
      n_checks++;
      if (miss_count !== sat(exp_miss)) begin
         n_bad++; $display("FAIL miss_after_sat got=%0d exp=%0d", miss_count, sat(exp_miss));
      end
      fetch(32'h0000_0248, 1'b1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_cold_and_hit();
      test_flush();
      test_conflict();
      test_back_to_back();
      test_stray_ready();
      test_reset_mid_miss();
      test_saturation();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
